// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus bundle: imem request/ack channel plus the output instruction buffer.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  // Memory / downstream side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request, one-entry output buffer,
// and redirect handling that drains any wrong-path request without buffering its data.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      bus
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [ADDR_W-1:0]  redir_pc_c;

  assign redir_pc_c = redirect_pc & ALIGN_MASK;

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;

  // Next-state and registered-output computation; redirect overrides every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    if (redirect) begin
      pc_d    = redir_pc_c;
      valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE, ST_WAIT_OUT: begin
          if (fetch_en) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
            addr_d  = redir_pc_c;
          end else begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            // Wrong-path data returned this cycle: drop it and restart immediately.
            state_d = ST_FETCH;
            req_d   = 1'b1;
            addr_d  = redir_pc_c;
          end else begin
            // Old request still outstanding: keep req/addr stable until it completes.
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_ack) begin
            if (fetch_en) begin
              state_d = ST_FETCH;
              req_d   = 1'b1;
              addr_d  = redir_pc_c;
            end else begin
              state_d = ST_IDLE;
              req_d   = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fetch_en) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
            req_d   = 1'b0;
            state_d = ST_WAIT_OUT;
          end
        end
        ST_WAIT_OUT: begin
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            if (fetch_en) begin
              state_d = ST_FETCH;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.imem_ack) begin
            if (fetch_en) begin
              state_d = ST_FETCH;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end else begin
              state_d = ST_IDLE;
              req_d   = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences for
// drain redirect, PC wrap, asynchronous clear and an 8-bit-address instance.
module tb_fetch_unit;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  logic        fetch_en    = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic       fe8  = 1'b0;
  logic       rd8  = 1'b0;
  logic [7:0] rpc8 = '0;

  int n_chk  = 0;
  int n_fail = 0;
  bit bad_seen = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
  fetch_unit_if #(.ADDR_W(8),  .INSTR_W(32)) bus8 ();

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .Clk(clk), .Clrn(clrn), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(bus)
  );

  fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'h0)) dut8 (
    .Clk(clk), .Clrn(clrn), .fetch_en(fe8), .redirect(rd8),
    .redirect_pc(rpc8), .bus(bus8)
  );

  typedef struct packed {
    logic        fe;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic fe, input logic rd, input logic [31:0] rpc,
                              input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc);
    vec_t v;
    v = '{fe, rd, rpc, ack, rdata, rdy, e_req, e_addr, e_valid, e_instr, e_ipc};
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fe, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] rdata, input logic rdy);
    fetch_en        = fe;
    redirect        = rd;
    redirect_pc     = rpc;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.instr_ready = rdy;
  endtask

  // Wrong-path data words must never be presented as a valid instruction.
  always @(negedge clk) begin
    if (bus.instr_valid && (bus.instr == 32'h0000_DEAD || bus.instr == 32'h3333_0000 ||
                            bus.instr == 32'h5555_0000))
      bad_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_req;
    drive(0, 0, 0, 0, 0, 0);
    bus8.imem_ack    = 1'b0;
    bus8.imem_rdata  = '0;
    bus8.instr_ready = 1'b0;

    // Streaming with zero-wait memory, rdata = addr ^ A5A5_0000
    add(1,0,0, 1,32'hA5A5_0000,1, 0,0,         0,0,0);
    add(1,0,0, 1,32'hA5A5_0000,1, 1,32'h0,     0,0,0);
    add(1,0,0, 1,32'hA5A5_0000,1, 0,0,         1,32'hA5A5_0000,32'h0);
    add(1,0,0, 1,32'hA5A5_0004,1, 1,32'h4,     0,0,0);
    add(1,0,0, 1,32'hA5A5_0004,1, 0,0,         1,32'hA5A5_0004,32'h4);
    add(1,0,0, 1,32'hA5A5_0008,1, 1,32'h8,     0,0,0);
    add(1,0,0, 1,32'hA5A5_0008,1, 0,0,         1,32'hA5A5_0008,32'h8);
    add(1,0,0, 1,32'hA5A5_000C,1, 1,32'hC,     0,0,0);
    add(0,0,0, 0,0,1,             0,0,         1,32'hA5A5_000C,32'hC);
    add(0,0,0, 1,32'hBAD0_0000,0, 0,0,         0,0,0);
    // Ack delayed 3 cycles, buffer held 4 cycles
    add(1,0,0, 0,0,0,             0,0,         0,0,0);
    add(1,0,0, 0,0,0,             1,32'h10,    0,0,0);
    add(1,0,0, 0,0,0,             1,32'h10,    0,0,0);
    add(1,0,0, 0,0,0,             1,32'h10,    0,0,0);
    add(1,0,0, 1,32'h1111_0010,0, 1,32'h10,    0,0,0);
    add(1,0,0, 1,32'hBAD0_0001,0, 0,0,         1,32'h1111_0010,32'h10);
    add(1,0,0, 0,0,0,             0,0,         1,32'h1111_0010,32'h10);
    add(1,0,0, 0,0,0,             0,0,         1,32'h1111_0010,32'h10);
    add(1,0,0, 0,0,0,             0,0,         1,32'h1111_0010,32'h10);
    add(1,0,0, 0,0,1,             0,0,         1,32'h1111_0010,32'h10);
    // Redirect to 0x100 while the 0x14 request awaits ack
    add(1,1,32'h100, 0,0,0,       1,32'h14,    0,0,0);
    add(1,0,0, 0,0,0,             1,32'h14,    0,0,0);
    add(1,0,0, 1,32'h0000_DEAD,0, 1,32'h14,    0,0,0);
    add(1,0,0, 1,32'h2222_0100,0, 1,32'h100,   0,0,0);
    // Redirect in WAIT_OUT with ready=1, unaligned target 0x103
    add(1,1,32'h103, 0,0,1,       0,0,         1,32'h2222_0100,32'h100);
    // Redirect coincident with ack
    add(1,1,32'h200, 1,32'h3333_0000,0, 1,32'h100, 0,0,0);
    add(1,0,0, 1,32'h4444_0200,0, 1,32'h200,   0,0,0);
    add(0,0,0, 0,0,1,             0,0,         1,32'h4444_0200,32'h200);
    add(0,0,0, 0,0,0,             0,0,         0,0,0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset req",      32'(bus.imem_req),    32'h0);
    chk("reset addr",     bus.imem_addr,        32'h0);
    chk("reset valid",    32'(bus.instr_valid), 32'h0);
    chk("reset instr",    bus.instr,            32'h0);
    chk("reset instr_pc", bus.instr_pc,         32'h0);
    clrn = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      chk($sformatf("row%0d req", i),   32'(bus.imem_req),    32'(vq[i].e_req));
      chk($sformatf("row%0d valid", i), 32'(bus.instr_valid), 32'(vq[i].e_valid));
      if (vq[i].e_req)
        chk($sformatf("row%0d addr", i), bus.imem_addr, vq[i].e_addr);
      if (vq[i].e_valid) begin
        chk($sformatf("row%0d instr", i),    bus.instr,    vq[i].e_instr);
        chk($sformatf("row%0d instr_pc", i), bus.instr_pc, vq[i].e_ipc);
      end
      drive(vq[i].fe, vq[i].rd, vq[i].rpc, vq[i].ack, vq[i].rdata, vq[i].rdy);
    end

    // Redirect twice while draining: pc follows the latest, drain still uses old address
    @(negedge clk); drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain req0", 32'(bus.imem_req), 32'h1);
    chk("drain addr0", bus.imem_addr, 32'h204);
    drive(1, 1, 32'h300, 0, 0, 0);
    @(negedge clk);
    chk("drain addr1", bus.imem_addr, 32'h204);
    drive(1, 1, 32'h400, 0, 0, 0);
    @(negedge clk);
    chk("drain addr2", bus.imem_addr, 32'h204);
    drive(1, 0, 0, 1, 32'h5555_0000, 0);
    @(negedge clk);
    chk("drain valid", 32'(bus.instr_valid), 32'h0);
    chk("drain next addr", bus.imem_addr, 32'h400);
    drive(1, 0, 0, 1, 32'h6666_0400, 0);
    @(negedge clk);
    chk("drain instr_pc", bus.instr_pc, 32'h400);
    chk("drain instr", bus.instr, 32'h6666_0400);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("drain idle valid", 32'(bus.instr_valid), 32'h0);

    // 32-bit PC wrap via unaligned redirect to 0xFFFF_FFFE
    drive(1, 1, 32'hFFFF_FFFE, 0, 0, 0);
    @(negedge clk);
    chk("wrap32 addr", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 1, 32'h7777_0000, 0);
    @(negedge clk);
    chk("wrap32 instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("wrap32 next req", 32'(bus.imem_req), 32'h1);
    chk("wrap32 next addr", bus.imem_addr, 32'h0);

    // Clear with the buffer full (pc has advanced to 4)
    drive(1, 0, 0, 1, 32'h8888_0000, 0);
    @(negedge clk);
    chk("full valid", 32'(bus.instr_valid), 32'h1);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("clr full valid",    32'(bus.instr_valid), 32'h0);
    chk("clr full instr",    bus.instr,            32'h0);
    chk("clr full instr_pc", bus.instr_pc,         32'h0);
    chk("clr full req",      32'(bus.imem_req),    32'h0);
    @(negedge clk);
    clrn = 1'b1;
    got_req = 1'b0;
    for (int c = 0; c < 8 && !got_req; c++) begin
      @(negedge clk);
      got_req = bus.imem_req;
    end
    chk("restart req seen", 32'(got_req), 32'h1);
    chk("restart addr", bus.imem_addr, 32'h0);

    // Clear in the middle of a request at address 4
    drive(1, 0, 0, 1, 32'h9999_0000, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("mid req", 32'(bus.imem_req), 32'h1);
    chk("mid addr", bus.imem_addr, 32'h4);
    clrn = 1'b0;
    #1;
    chk("clr mid req",  32'(bus.imem_req), 32'h0);
    chk("clr mid addr", bus.imem_addr,     32'h0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid restart addr", bus.imem_addr, 32'h0);
    drive(0, 0, 0, 0, 0, 0);

    // 8-bit address instance: pc 0xFC wraps to 0x00
    @(negedge clk);
    fe8 = 1'b1; rd8 = 1'b1; rpc8 = 8'hFC;
    @(negedge clk);
    chk("w8 req", 32'(bus8.imem_req), 32'h1);
    chk("w8 addr", 32'(bus8.imem_addr), 32'hFC);
    rd8 = 1'b0; bus8.imem_ack = 1'b1; bus8.imem_rdata = 32'hAAAA_00FC;
    @(negedge clk);
    chk("w8 instr_pc", 32'(bus8.instr_pc), 32'hFC);
    chk("w8 instr", bus8.instr, 32'hAAAA_00FC);
    bus8.imem_ack = 1'b0; bus8.instr_ready = 1'b1;
    @(negedge clk);
    chk("w8 wrap req", 32'(bus8.imem_req), 32'h1);
    chk("w8 wrap addr", 32'(bus8.imem_addr), 32'h00);
    fe8 = 1'b0;

    chk("wrong-path data never buffered", 32'(bad_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
